input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Parametrised multi-channel front end for the board's buttons and switches (BTN_LEFT/RIGHT/A/B, SW_*). It replaces ad-hoc per-input synchronisers.
- Per channel: metastability synchroniser, counter-based debouncer, registered press/release edge pulses, and optional hold-to-auto-repeat.
- Sits between the raw pins and the game/paddle logic, in the CLK_40M domain.

Parameters:
- CHANNELS, 4, number of independent input channels.
- SYNC_STAGES, 2, flip-flops in the synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 400000, consecutive cycles a new synchronised level must persist before it is accepted (10 ms at 40 MHz); minimum 1.
- REPEAT_DELAY, 12000000, cycles from the PRESS pulse to the first REPEAT pulse (300 ms); minimum 1.
- REPEAT_PERIOD, 4000000, cycles between subsequent REPEAT pulses (100 ms); minimum 1.
- CNT_WIDTH, derived as clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1, width of the internal counters; not overridden.

Ports:
- CLK_40M  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RAW_IN  in  CHANNELS  raw, asynchronous, active-high inputs.
- REPEAT_EN  in  CHANNELS  per-channel auto-repeat enable; synchronous, already in the clock domain.
- LEVEL  out  CHANNELS  debounced level.
- PRESS  out  CHANNELS  one-cycle pulse on an accepted 0->1 transition.
- RELEASE  out  CHANNELS  one-cycle pulse on an accepted 1->0 transition.
- REPEAT  out  CHANNELS  one-cycle auto-repeat pulse.
- EVENT  out  CHANNELS  PRESS | REPEAT (registered OR of the two); the paddle logic consumes this.

Behaviour:
- Reset: while RESET_N is low, all synchroniser flops, LEVEL, PRESS, RELEASE, REPEAT, EVENT and all counters are 0. Reset takes effect immediately, including mid-debounce or mid-repeat; no pulse is emitted on entering or leaving reset.
- Channels are fully independent; there is no cross-channel coupling.
- Synchroniser: RAW_IN passes through SYNC_STAGES flops. Call the output sync.
- Debounce (per channel): counter dcnt.
  - If sync == LEVEL: dcnt <= 0.
  - Else, if dcnt == DEBOUNCE_CYCLES-1: LEVEL <= sync and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
- Debounce latency: number edges from the first edge that samples a new stable RAW_IN value as edge 1. LEVEL changes at edge SYNC_STAGES+DEBOUNCE_CYCLES. Any RAW_IN excursion shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- PRESS and RELEASE are asserted on the same edge that LEVEL changes and are high for exactly 1 cycle.
- After reset with RAW_IN already high, the channel reports a normal PRESS after the debounce latency.
- Repeat FSM (per channel): states IDLE, DELAY, RPT; counter rcnt.
  - IDLE -> DELAY when LEVEL goes 0->1 and REPEAT_EN=1; rcnt <= 1 on that edge.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY: REPEAT pulses, go to RPT, rcnt <= 1.
  - RPT: rcnt increments each cycle. When rcnt == REPEAT_PERIOD: REPEAT pulses, rcnt <= 1.
  - Any state -> IDLE (rcnt <= 0, no REPEAT) on the edge LEVEL goes 1->0, or in any cycle REPEAT_EN=0. Release and disable take priority over a coincident REPEAT.
  - Re-asserting REPEAT_EN while the input is held does not restart repeat; the next PRESS does.
- Repeat timing: if PRESS is high in cycle P, REPEAT is high in cycles P+REPEAT_DELAY, then P+REPEAT_DELAY+k*REPEAT_PERIOD for k>=1.
- REPEAT never coincides with PRESS. EVENT is high in exactly the cycles where PRESS or REPEAT is high.
- Counters saturate by construction and never wrap; no width overflow for legal parameters.

Test Plan:
1. Settings CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 apply to all scenarios. Reset, then hold RAW_IN=0 -> all outputs 0 for 20 cycles, and still 0 with RESET_N held low while RAW_IN toggles.
2. RAW_IN[0] rises and stays high -> LEVEL[0] rises at edge 6. PRESS[0] and EVENT[0] are high for exactly 1 cycle at that edge. Falling RAW_IN[0] -> LEVEL[0] falls 6 edges later with a 1-cycle RELEASE[0].
3. RAW_IN[1] glitches high for 3 cycles, then 0 for 1 cycle, then high for 3 cycles -> LEVEL[1], PRESS[1] and RELEASE[1] stay 0 throughout.
4. REPEAT_EN[2]=1 and RAW_IN[2] held with PRESS in cycle P -> REPEAT[2] and EVENT[2] high at P+10, P+13, P+16. Release -> no REPEAT from the cycle LEVEL[2] falls.
5. REPEAT_EN[3]=1, hold until after the first repeat at P+10, then drop REPEAT_EN[3] at P+12 -> no REPEAT at P+13 or later. Re-enable at P+20 -> still no REPEAT until the next press.
6. Pulse RESET_N low mid-repeat and mid-debounce on channels 0-3 -> all outputs go to 0 asynchronously. After release, held inputs produce PRESS exactly 6 edges later.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw inputs and repeat enables in,
// debounced level and event pulses out.
interface input_conditioner_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] RAW_IN;
    logic [CHANNELS-1:0] REPEAT_EN;
    logic [CHANNELS-1:0] LEVEL;
    logic [CHANNELS-1:0] PRESS;
    logic [CHANNELS-1:0] RELEASE;
    logic [CHANNELS-1:0] REPEAT;
    logic [CHANNELS-1:0] EVENT;

    modport master (
        output RAW_IN,
        output REPEAT_EN,
        input  LEVEL,
        input  PRESS,
        input  RELEASE,
        input  REPEAT,
        input  EVENT
    );

    modport slave (
        input  RAW_IN,
        input  REPEAT_EN,
        output LEVEL,
        output PRESS,
        output RELEASE,
        output REPEAT,
        output EVENT
    );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel button/switch front end: synchroniser, counter debouncer,
// press/release pulses and hold-to-auto-repeat, all per independent channel.
module input_conditioner #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 400000,
    parameter int unsigned REPEAT_DELAY    = 12000000,
    parameter int unsigned REPEAT_PERIOD   = 4000000
) (
    input  logic                 CLK_40M,
    input  logic                 RESET_N,
    input_conditioner_if.slave   io
);

    localparam int unsigned MAX_DR    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT   = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_CNT + 1);

    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY);
    localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_e;

    logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
    logic [CNT_WIDTH-1:0]   dcnt_q  [CHANNELS];
    logic [CNT_WIDTH-1:0]   rcnt_q  [CHANNELS];
    rpt_state_e             state_q [CHANNELS];

    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] release_q;
    logic [CHANNELS-1:0] repeat_q;
    logic [CHANNELS-1:0] event_q;

    logic [CHANNELS-1:0] sync_c;
    logic [CHANNELS-1:0] rise_c;
    logic [CHANNELS-1:0] fall_c;
    logic [CHANNELS-1:0] rep_c;

    // Accepted level changes and repeat firing for the coming edge.
    always_comb begin
        sync_c = '0;
        rise_c = '0;
        fall_c = '0;
        rep_c  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sync_c[i] = sync_q[i][SYNC_STAGES-1];
            rise_c[i] = sync_c[i] & ~level_q[i] & (dcnt_q[i] == DB_LAST);
            fall_c[i] = ~sync_c[i] & level_q[i] & (dcnt_q[i] == DB_LAST);
            // Release and disable suppress a coincident repeat.
            rep_c[i]  = io.REPEAT_EN[i] & ~fall_c[i] &
                        (((state_q[i] == DELAY) && (rcnt_q[i] == RD_LAST)) ||
                         ((state_q[i] == RPT)   && (rcnt_q[i] == RP_LAST)));
        end
    end

    always_ff @(posedge CLK_40M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= '0;
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            event_q   <= '0;
        end else begin
            press_q   <= rise_c;
            release_q <= fall_c;
            repeat_q  <= rep_c;
            event_q   <= rise_c | rep_c;
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], io.RAW_IN[i]};

                if (sync_c[i] == level_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DB_LAST) begin
                    level_q[i] <= sync_c[i];
                    dcnt_q[i]  <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + CNT_ONE;
                end

                // Repeat only arms on a press seen with the enable high.
                if (fall_c[i] || !io.REPEAT_EN[i]) begin
                    state_q[i] <= IDLE;
                    rcnt_q[i]  <= '0;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            if (rise_c[i]) begin
                                state_q[i] <= DELAY;
                                rcnt_q[i]  <= CNT_ONE;
                            end
                        end
                        DELAY: begin
                            if (rcnt_q[i] == RD_LAST) begin
                                state_q[i] <= RPT;
                                rcnt_q[i]  <= CNT_ONE;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + CNT_ONE;
                            end
                        end
                        RPT: begin
                            if (rcnt_q[i] == RP_LAST) begin
                                rcnt_q[i] <= CNT_ONE;
                            end else begin
                                rcnt_q[i] <= rcnt_q[i] + CNT_ONE;
                            end
                        end
                        default: begin
                            state_q[i] <= IDLE;
                            rcnt_q[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign io.LEVEL   = level_q;
    assign io.PRESS   = press_q;
    assign io.RELEASE = release_q;
    assign io.REPEAT  = repeat_q;
    assign io.EVENT   = event_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random stimulus, all
// checked against a window/arithmetic reference model.
module tb_input_conditioner;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
    localparam int unsigned VW = 5 * CH;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] raw_v = '0;
    logic [CH-1:0] en_v  = '0;
    int            checks = 0;
    int            errors = 0;

    // Reference model state
    logic [CH-1:0] hist [$];
    logic [CH-1:0] m_level, m_press, m_rel, m_rep, m_evt;
    bit            armed [CH];
    int            pcyc  [CH];
    int            n;

    always #5 clk = ~clk;

    input_conditioner_if #(.CHANNELS(CH)) io ();

    input_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK_40M (clk),
        .RESET_N (rst_n),
        .io      (io)
    );

    function automatic logic [VW-1:0] dut_vec();
        return {io.LEVEL, io.PRESS, io.RELEASE, io.REPEAT, io.EVENT};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_level, m_press, m_rel, m_rep, m_evt};
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < int'(SS + DB); i++) hist.push_front('0);
        m_level = '0; m_press = '0; m_rel = '0; m_rep = '0; m_evt = '0;
        for (int c = 0; c < int'(CH); c++) begin
            armed[c] = 1'b0;
            pcyc[c]  = 0;
        end
        n = 0;
    endfunction

    // A level is accepted when the last DB synchronised samples all disagree
    // with it; repeats are placed arithmetically from the press cycle.
    function automatic void model_edge(input logic [CH-1:0] raw, input logic [CH-1:0] en);
        bit window_ok;
        int d;
        n++;
        hist.push_front(raw);
        while (hist.size() > int'(SS + DB)) void'(hist.pop_back());
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int c = 0; c < int'(CH); c++) begin
            window_ok = 1'b1;
            for (int j = 0; j < int'(DB); j++)
                if (hist[SS + j][c] == m_level[c]) window_ok = 1'b0;
            if (window_ok) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) m_press[c] = 1'b1;
                else            m_rel[c]   = 1'b1;
            end
            if (m_rel[c] || !en[c]) begin
                armed[c] = 1'b0;
            end else if (m_press[c]) begin
                armed[c] = 1'b1;
                pcyc[c]  = n;
            end else if (armed[c]) begin
                d = n - pcyc[c];
                if (d == int'(RD) || (d > int'(RD) && (d - int'(RD)) % int'(RP) == 0))
                    m_rep[c] = 1'b1;
            end
        end
        m_evt = m_press | m_rep;
    endfunction

    // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
    task automatic step();
        io.RAW_IN    = raw_v;
        io.REPEAT_EN = en_v;
        @(posedge clk);
        if (rst_n) model_edge(raw_v, en_v);
        @(negedge clk);
    endtask

    task automatic test_reset();
        raw_v = '0; en_v = '0;
        io.RAW_IN = '0; io.REPEAT_EN = '0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== VW'(0)) begin
            errors++; $display("FAIL reset_async dut=%h exp=%h", dut_vec(), VW'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (dut_vec() !== VW'(0)) begin
                errors++; $display("FAIL reset_idle cyc=%0d dut=%h exp=%h", k, dut_vec(), VW'(0));
            end
        end
        rst_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            raw_v = CH'($urandom);
            en_v  = CH'($urandom);
            step();
            checks++;
            if (dut_vec() !== VW'(0)) begin
                errors++; $display("FAIL reset_held cyc=%0d dut=%h exp=%h", k, dut_vec(), VW'(0));
            end
        end
        raw_v = '0; en_v = '0;
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL reset_release t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_debounce();
        int rise_at = -1, press_at = -1, press_n = 0, evt_n = 0;
        int fall_at = -1, rel_at = -1, rel_n = 0;
        raw_v[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL debounce_rise_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            if (io.LEVEL[0] && rise_at < 0) rise_at = e;
            if (io.PRESS[0]) press_at = e;
            press_n += int'(io.PRESS[0]);
            evt_n   += int'(io.EVENT[0]);
        end
        checks++;
        if (rise_at != int'(SS + DB)) begin
            errors++; $display("FAIL level_rise_edge got=%0d exp=%0d", rise_at, SS + DB);
        end
        checks++;
        if (press_at != int'(SS + DB) || press_n != 1 || evt_n != 1) begin
            errors++; $display("FAIL press_pulse at=%0d n=%0d evt=%0d exp at=%0d n=1 evt=1", press_at, press_n, evt_n, SS + DB);
        end
        raw_v[0] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL debounce_fall_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            if (!io.LEVEL[0] && fall_at < 0) fall_at = e;
            if (io.RELEASE[0]) rel_at = e;
            rel_n += int'(io.RELEASE[0]);
        end
        checks++;
        if (fall_at != int'(SS + DB) || rel_at != int'(SS + DB) || rel_n != 1) begin
            errors++; $display("FAIL release_pulse fall=%0d at=%0d n=%0d exp=%0d n=1", fall_at, rel_at, rel_n, SS + DB);
        end
    endtask

    task automatic test_glitch();
        int pat [7] = '{1, 1, 1, 0, 1, 1, 1};
        bit seen = 1'b0;
        for (int k = 0; k < 17; k++) begin
            raw_v[1] = (k < 7) ? (pat[k] != 0) : 1'b0;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL glitch_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            seen |= io.LEVEL[1] | io.PRESS[1] | io.RELEASE[1];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL glitch_ignored got=%0b exp=0", seen);
        end
    endtask

    task automatic test_repeat();
        int p = -1, d, hits = 0, fall_e = -1, late = 0;
        logic exp_r;
        en_v[2]  = 1'b1;
        raw_v[2] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL repeat_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            if (io.PRESS[2]) p = e;
            if (p >= 0 && e > p) begin
                d = e - p;
                exp_r = (d == int'(RD)) || (d > int'(RD) && (d - int'(RD)) % int'(RP) == 0);
                checks++;
                if (io.REPEAT[2] !== exp_r || io.EVENT[2] !== exp_r) begin
                    errors++; $display("FAIL repeat_timing d=%0d rep=%0b evt=%0b exp=%0b", d, io.REPEAT[2], io.EVENT[2], exp_r);
                end
                if (d == int'(RD) || d == int'(RD + RP) || d == int'(RD + 2 * RP)) hits += int'(io.REPEAT[2]);
            end
        end
        checks++;
        if (p != int'(SS + DB) || hits != 3) begin
            errors++; $display("FAIL repeat_first_three press=%0d hits=%0d exp press=%0d hits=3", p, hits, SS + DB);
        end
        raw_v[2] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL repeat_release_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            if (!io.LEVEL[2] && fall_e < 0) fall_e = e;
            if (fall_e >= 0 && io.REPEAT[2]) late++;
        end
        checks++;
        if (fall_e != int'(SS + DB) || late != 0) begin
            errors++; $display("FAIL repeat_after_release fall=%0d late=%0d exp fall=%0d late=0", fall_e, late, SS + DB);
        end
        en_v[2] = 1'b0;
    endtask

    task automatic test_repeat_disable();
        int p = -1, c, extra = 0;
        logic exp_r;
        en_v[3]  = 1'b1;
        raw_v[3] = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            if (p >= 0) begin
                c = e - 1 - p;
                en_v[3] = !(c >= 12 && c < 20);
            end
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL disable_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
            if (io.PRESS[3]) begin
                if (p < 0) p = e;
                else       extra++;
            end
            if (p >= 0 && e > p) begin
                exp_r = (e == p + int'(RD));
                checks++;
                if (io.REPEAT[3] !== exp_r) begin
                    errors++; $display("FAIL disable_repeat d=%0d rep=%0b exp=%0b", e - p, io.REPEAT[3], exp_r);
                end
            end
        end
        checks++;
        if (p != int'(SS + DB) || extra != 0) begin
            errors++; $display("FAIL disable_press press=%0d extra=%0d exp press=%0d extra=0", p, extra, SS + DB);
        end
        raw_v[3] = 1'b0;
        for (int e = 0; e < 12; e++) step();
        en_v[3] = 1'b0;
        for (int e = 0; e < 2; e++) step();
    endtask

    task automatic test_reset_mid();
        logic [CH-1:0] exp_p;
        raw_v = '1; en_v = '1;
        for (int e = 0; e < 18; e++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL mid_pre_model t=%0t dut=%h exp=%h", $time, dut_vec(), model_vec());
            end
        end
        raw_v[1] = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== VW'(0)) begin
            errors++; $display("FAIL reset_mid_async dut=%h exp=%h", dut_vec(), VW'(0));
        end
        @(negedge clk);
        raw_v[1] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            checks++;
            if (dut_vec() !== VW'(0)) begin
                errors++; $display("FAIL reset_mid_held dut=%h exp=%h", dut_vec(), VW'(0));
            end
        end
        model_reset();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp_p = (e == int'(SS + DB)) ? '1 : '0;
            checks++;
            if (io.PRESS !== exp_p || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL reset_mid_press edge=%0d press=%b exp=%b dut=%h model=%h", e, io.PRESS, exp_p, dut_vec(), model_vec());
            end
        end
        raw_v = '0; en_v = '0;
        for (int e = 0; e < 12; e++) step();
    endtask

    task automatic test_random();
        int lim;
        for (int phase = 0; phase < 2; phase++) begin
            lim = (phase == 0) ? 5 : 39;
            if (phase == 1) en_v = '1;
            for (int k = 0; k < 1500; k++) begin
                for (int c = 0; c < int'(CH); c++) begin
                    if ($urandom_range(0, lim) == 0) raw_v[c] = ~raw_v[c];
                    if ($urandom_range(0, 59) == 0)  en_v[c]  = ~en_v[c];
                end
                step();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL random_model phase=%0d k=%0d dut=%h exp=%h", phase, k, dut_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_repeat();
        test_repeat_disable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
